// File: rtl/rpn_stack_pop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rpn_defs (package)
// Description : Shared state codes, width defaults and operand-count constants
//               for the RPN operand stack.
// Revision    : 1.0 - initial release
// ============================================================================
package rpn_defs;

    localparam int unsigned c_DATA_W_DEFAULT = 8;
    localparam int unsigned c_SP_W_DEFAULT   = 8;

    localparam int unsigned c_OPS_ONE = 1;
    localparam int unsigned c_OPS_TWO = 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_RD_A  = 4'd1,
        ST_RD_B  = 4'd2,
        ST_CAP_B = 4'd3,
        ST_CAP_A = 4'd4,
        ST_DONE  = 4'd5,
        ST_ERR   = 4'd6
    } pop_state_t;

endpackage : rpn_defs
`default_nettype wire

// File: rtl/rpn_stack_pop.sv
`default_nettype none
// ============================================================================
// Module      : rpn_stack_pop
// Description : Read side of the RPN operand stack; pops one or two operands
//               and hands back the decremented stack pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rpn_stack_pop
    import rpn_defs::*;
#(
    parameter int unsigned DATA_W = c_DATA_W_DEFAULT,
    parameter int unsigned SP_W   = c_SP_W_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic              two_ops,
    input  logic [SP_W-1:0]   sp_in,
    output logic [SP_W-1:0]   mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [SP_W-1:0]   sp_out,
    output logic              sp_we,
    output logic              busy,
    output logic              done,
    output logic              underflow
);

    pop_state_t        r_state;
    logic [SP_W-1:0]   r_sp_q;
    logic              r_n_q;
    logic [SP_W-1:0]   r_mem_addr;
    logic              r_mem_rd_en;
    logic [DATA_W-1:0] r_operand_a;
    logic [DATA_W-1:0] r_operand_b;
    logic [SP_W-1:0]   r_sp_out;
    logic              r_sp_we;
    logic              r_busy;
    logic              r_done;
    logic              r_underflow;

    logic [SP_W-1:0]   w_need;

    assign w_need = two_ops ? SP_W'(c_OPS_TWO) : SP_W'(c_OPS_ONE);

    // Outputs are computed one state ahead so every port comes straight
    // from a flop while still matching the state it belongs to.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sp_q      <= '0;
            r_n_q       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_sp_out    <= '0;
            r_sp_we     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_sp_we     <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sp_q <= sp_in;
                        r_n_q  <= two_ops;
                        r_busy <= 1'b1;
                        if (sp_in < w_need) begin
                            r_state     <= ST_ERR;
                            r_underflow <= 1'b1;
                        end else begin
                            r_state     <= ST_RD_A;
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= sp_in - SP_W'(1);
                        end
                    end
                end
                ST_RD_A: begin
                    if (r_n_q) begin
                        r_state     <= ST_RD_B;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_sp_q - SP_W'(2);
                    end else begin
                        r_state <= ST_CAP_A;
                    end
                end
                ST_RD_B: begin
                    r_operand_a <= mem_rdata;
                    r_state     <= ST_CAP_B;
                end
                ST_CAP_A: begin
                    r_operand_a <= mem_rdata;
                    r_state     <= ST_DONE;
                    r_done      <= 1'b1;
                    r_sp_we     <= 1'b1;
                    r_sp_out    <= r_sp_q - SP_W'(1);
                end
                ST_CAP_B: begin
                    r_operand_b <= mem_rdata;
                    r_state     <= ST_DONE;
                    r_done      <= 1'b1;
                    r_sp_we     <= 1'b1;
                    r_sp_out    <= r_sp_q - SP_W'(2);
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign operand_a = r_operand_a;
    assign operand_b = r_operand_b;
    assign sp_out    = r_sp_out;
    assign sp_we     = r_sp_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign underflow = r_underflow;

endmodule : rpn_stack_pop
`default_nettype wire

// File: doc/rpn_stack_pop.md
Name: rpn_stack_pop

Overview:
- Read side of the RPN operand stack.
- The existing push path writes switch values into stack memory and advances the 8-bit stack pointer. This block pops one or two operands from the same memory and returns them to the ALU sequencer, then writes back the decremented pointer.
- Owns the stack memory read port only. The stack pointer register stays external and is updated through sp_out/sp_we.

Parameters:
- DATA_W, 8: operand width, matching the push path data width.
- SP_W, 8: stack pointer width; stack depth is 2**SP_W.

Ports:
- CLOCK_50 input 1: single system clock; all state changes on its rising edge.
- reset_n input 1: asynchronous, active-low reset.
- start input 1: pop request; sampled only in IDLE.
- two_ops input 1: sampled with start; 0 = pop one operand, 1 = pop two.
- sp_in input SP_W: current stack pointer, i.e. the count of valid entries. sp_in = 0 means empty; the top of stack is at sp_in-1.
- mem_addr output SP_W: stack memory read address.
- mem_rd_en output 1: read strobe to stack memory.
- mem_rdata input DATA_W: read data, valid exactly one cycle after a mem_rd_en cycle.
- operand_a output DATA_W: top of stack, held after done.
- operand_b output DATA_W: second entry; held after a two-operand done, otherwise unchanged.
- sp_out output SP_W: new stack pointer value.
- sp_we output 1: one-cycle write strobe for the external stack pointer register.
- busy output 1: high in every state except IDLE.
- done output 1: one-cycle pulse when the operands are valid.
- underflow output 1: one-cycle pulse when a request is rejected.

Behaviour:
- Reset (asynchronous, any state): state = IDLE; operand_a, operand_b, sp_out = 0; sp_we, mem_rd_en, done, underflow, busy = 0.
  - A pop interrupted by reset issues no sp_we.
- States: IDLE, RD_A, RD_B, CAP_B, CAP_A, DONE, ERR. Transitions are evaluated on each CLOCK_50 edge.
- IDLE with start=1:
  - Snapshot sp_in into sp_q and two_ops into n_q.
  - If sp_in < (two_ops ? 2 : 1): go to ERR.
  - Otherwise go to RD_A.
  - start in any other state is ignored; there is no queuing.
- RD_A: mem_rd_en = 1, mem_addr = sp_q-1.
  - n_q = 1: go to RD_B.
  - n_q = 0: go to CAP_A.
- RD_B: mem_rd_en = 1, mem_addr = sp_q-2; operand_a <= mem_rdata; go to CAP_B.
- CAP_A: operand_a <= mem_rdata; go to DONE.
- CAP_B: operand_b <= mem_rdata; go to DONE.
- DONE:
  - done = 1, sp_we = 1.
  - sp_out = sp_q-1 for one operand, sp_q-2 for two.
  - Go to IDLE.
- ERR: underflow = 1; no memory read, no sp_we; operands unchanged; go to IDLE.
- mem_addr = 0 whenever mem_rd_en = 0.
- Latency after the start edge:
  - One operand: done in the 3rd cycle.
  - Two operands: done in the 4th cycle.
  - Underflow: underflow in the 1st cycle.
  - Back-to-back pops: the next start is accepted in the cycle after DONE, so throughput is one pop per 4 (one operand) or 5 (two operands) cycles.
- Arithmetic:
  - All pointer math is unsigned SP_W-bit.
  - Underflow checks guarantee no wrap below 0.
  - sp_in = 2**SP_W-1 (full) pops normally.
- Simultaneous events: if the push path changes sp_in while busy, the change is ignored; sp_q governs. Arbitration is the sequencer's job, and the sequencer never pushes while busy = 1.
- The module drives no outputs combinationally from inputs. All outputs are decoded from registered state or are registers, so there is no start-to-output combinational path.

Decomposition:
- Shared package/header rpn_defs holds:
  - the state encodings (4-bit codes, same style as the push FSM);
  - the DATA_W/SP_W defaults;
  - the operand-count constants.
- No sub-module is needed. The operand registers need reset, so the non-resettable reg_load_enable is not reused. Single module, about 150 lines.

Test Plan:
- Memory preloaded [0]=0x11, [1]=0x22, [2]=0x33; sp_in=3; start, two_ops=0 -> mem_addr=2 in cycle 1; done in cycle 3; operand_a=0x33; sp_we pulse with sp_out=2.
- Same memory, sp_in=3, two_ops=1 -> addresses 2 then 1 on consecutive cycles; done in cycle 4; operand_a=0x33, operand_b=0x22, sp_out=1.
- sp_in=1, two_ops=1 -> underflow pulse in cycle 1; no mem_rd_en, no sp_we, no done; operands unchanged.
- sp_in=0, two_ops=0 -> underflow pulse; then sp_in=1, start -> operand_a=mem[0], sp_out=0.
- Assert reset_n low during RD_B of a two-operand pop -> all outputs 0 immediately; no sp_we ever pulses; a fresh start after release behaves as in scenario 2.
- Pulse start again during RD_A -> ignored: exactly one done and one sp_we occur; busy stays high through DONE.
